// File: rtl/router_reg_core_if.sv
// Router register-stage busy interface: FSM state decodes and qualifiers in, busy flag out.
// busy_cnt exists only when ROUTER_REG_BUSY_CNT_EN is defined.
interface router_reg_core_if #(
  parameter int CNT_W = 16
);
  logic detect_add;
  logic ld_state;
  logic laf_state;
  logic full_state;
  logic empty_state;
  logic write_enb_reg;
  logic pkt_valid;
  logic rst_int_reg;
  logic busy;
`ifdef ROUTER_REG_BUSY_CNT_EN
  logic [CNT_W-1:0] busy_cnt;
`endif

  // master: FSM/datapath side producing decodes and consuming busy
  modport master (
    output detect_add, ld_state, laf_state, full_state, empty_state,
           write_enb_reg, pkt_valid, rst_int_reg,
`ifdef ROUTER_REG_BUSY_CNT_EN
    input  busy_cnt,
`endif
    input  busy
  );

  // slave: the busy generator itself
  modport slave (
    input  detect_add, ld_state, laf_state, full_state, empty_state,
           write_enb_reg, pkt_valid, rst_int_reg,
`ifdef ROUTER_REG_BUSY_CNT_EN
    output busy_cnt,
`endif
    output busy
  );
endinterface

// File: rtl/router_reg_core.sv
// Registered busy/stall generator for the 1x3 router register stage.
// Optional saturating busy-cycle counter enabled by ROUTER_REG_BUSY_CNT_EN.
module router_reg_core #(
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            resetn,   // synchronous, active-high despite the name
  router_reg_core_if.slave bus
);

  logic busy_nxt;

  always_comb begin
    busy_nxt = bus.detect_add
             | bus.ld_state
             | (bus.laf_state & (~bus.full_state | bus.pkt_valid))
             | (bus.empty_state & bus.write_enb_reg)
             | bus.rst_int_reg;
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (resetn) bus.busy <= 1'b0;
    else        bus.busy <= busy_nxt;
  end

`ifdef ROUTER_REG_BUSY_CNT_EN
  // Counts edges where the registered busy was high; holds at all-ones.
  always_ff @(posedge clk) begin
    if (resetn)
      bus.busy_cnt <= '0;
    else if (bus.busy && (bus.busy_cnt != {CNT_W{1'b1}}))
      bus.busy_cnt <= bus.busy_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_router_reg_core.sv
// Directed self-checking bench for router_reg_core; counter checks run when
// ROUTER_REG_BUSY_CNT_EN is defined.
module tb_router_reg_core;
  localparam int CNT_W = 2;

  logic clk;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  router_reg_core_if #(.CNT_W(CNT_W)) bus ();

  router_reg_core #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change at negedge; one posedge later outputs are sampled at the next negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] v);
    // v = {detect_add, ld, laf, full, empty, web, pkt_valid, rst_int}
    bus.detect_add    = v[7];
    bus.ld_state      = v[6];
    bus.laf_state     = v[5];
    bus.full_state    = v[4];
    bus.empty_state   = v[3];
    bus.write_enb_reg = v[2];
    bus.pkt_valid     = v[1];
    bus.rst_int_reg   = v[0];
  endtask

  // Directed vectors: inputs, expected busy after one edge.
  typedef struct { logic [7:0] v; logic exp; string tag; } vec_t;
  vec_t vecs[$];

  initial begin
    vecs.push_back('{8'b1000_0000, 1'b1, "detect_add_only"});
    vecs.push_back('{8'b0100_0000, 1'b1, "ld_state_only"});
    vecs.push_back('{8'b0000_0000, 1'b0, "all_low"});
    vecs.push_back('{8'b0011_0010, 1'b1, "laf_full_pkt"});
    vecs.push_back('{8'b0011_0000, 1'b0, "laf_full_nopkt"});
    vecs.push_back('{8'b0010_0000, 1'b1, "laf_notfull_nopkt"});
    vecs.push_back('{8'b0010_0010, 1'b1, "laf_notfull_pkt"});
    vecs.push_back('{8'b0000_1100, 1'b1, "empty_web"});
    vecs.push_back('{8'b0000_1000, 1'b0, "empty_noweb"});
    vecs.push_back('{8'b0000_0001, 1'b1, "rst_int_only"});
    vecs.push_back('{8'b0000_0100, 1'b0, "web_only"});
    vecs.push_back('{8'b0001_0010, 1'b0, "full_pkt_no_laf"});
    vecs.push_back('{8'b1110_1101, 1'b1, "multi_term_or"});
    vecs.push_back('{8'b0000_0000, 1'b0, "all_low_again"});

    drive(8'b1000_0000);
    resetn = 1'b1;
    @(negedge clk);
    tick();
    check("reset_cycle1", bus.busy, 1'b0);
    tick();
    check("reset_cycle2", bus.busy, 1'b0);
`ifdef ROUTER_REG_BUSY_CNT_EN
    check("reset_cnt", bus.busy_cnt, 0);
`endif
    resetn = 1'b0;
    tick();
    check("reset_release", bus.busy, 1'b1);

    foreach (vecs[i]) begin
      drive(vecs[i].v);
      tick();
      check(vecs[i].tag, bus.busy, vecs[i].exp);
    end

    // Latency: no combinational path, change shows exactly one edge later.
    drive(8'b0100_0000);
    #1;
    check("latency_before_edge", bus.busy, 1'b0);
    @(posedge clk);
    #1;
    check("latency_after_edge", bus.busy, 1'b1);
    @(negedge clk);

    // Reset mid-operation dominates every term.
    drive(8'b1111_1111);
    resetn = 1'b1;
    tick();
    check("reset_dominates", bus.busy, 1'b0);

`ifdef ROUTER_REG_BUSY_CNT_EN
    check("cnt_cleared", bus.busy_cnt, 0);
    drive(8'b1000_0000);
    resetn = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 3) check("cnt_mid", bus.busy_cnt, 2);
    end
    check("cnt_saturate", bus.busy_cnt, 3);
    check("cnt_busy_held", bus.busy, 1'b1);
    resetn = 1'b1;
    tick();
    check("cnt_reset", bus.busy_cnt, 0);
    check("cnt_reset_busy", bus.busy, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_reg_core.md
Name: router_reg_core

Overview:
- Busy/stall generator for the 1x3 router datapath register stage.
- Consumes FSM state decodes (detect_add, ld_state, laf_state, full_state, empty_state) and datapath qualifiers (pkt_valid, write_enb_reg, rst_int_reg).
- Produces a registered busy flag telling the upstream source to hold off driving new packet bytes.
- Sits between the router FSM and the input interface.

Parameters:
- CNT_W, 16, width of the optional busy-cycle counter. Only used when ROUTER_REG_BUSY_CNT_EN is defined; legal range 2..32.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- resetn  input  1  synchronous, active-high reset, sampled on the rising edge of clk. Keeps the codebase port name; polarity is high despite the suffix.
- detect_add  input  1  FSM in DECODE_ADDRESS state.
- ld_state  input  1  FSM in LOAD_DATA state.
- laf_state  input  1  FSM in LOAD_AFTER_FULL state.
- full_state  input  1  FSM in FIFO_FULL_STATE.
- empty_state  input  1  FSM in WAIT_TILL_EMPTY state.
- write_enb_reg  input  1  FSM write-enable request.
- pkt_valid  input  1  source indicates packet byte valid.
- rst_int_reg  input  1  internal register reset / parity-check phase indicator.
- busy  output  1  registered stall flag to source.
- busy_cnt  output  CNT_W  saturating busy-cycle count. Present only with ROUTER_REG_BUSY_CNT_EN.

Behaviour:
- busy_nxt = detect_add | ld_state | (laf_state & (~full_state | pkt_valid)) | (empty_state & write_enb_reg) | rst_int_reg.
- busy is a flop. On each rising clk edge:
  - resetn=1 forces busy<=0.
  - Otherwise busy<=busy_nxt.
- Latency: exactly one clock from input change to busy change. Inputs are not combinationally reflected on busy.
- Reset value: busy=0 (and busy_cnt=0 when present).
- Reset dominates all other inputs in the same cycle.
- Reset asserted mid-operation clears busy at the next edge, whatever the FSM inputs are.
- Simultaneous terms are OR-combined; no priority among them.
- Any single term alone drives busy=1.
- laf_state boundary cases:
  - laf_state=1, full_state=1, pkt_valid=0 (nothing else high) gives busy=0.
  - laf_state=1, full_state=1, pkt_valid=1 gives busy=1.
  - laf_state=1, full_state=0 gives busy=1, independent of pkt_valid.
- empty_state contributes only when write_enb_reg=1. empty_state=1 with write_enb_reg=0 alone gives busy=0.
- All inputs low gives busy=0 at the next edge.
- Inputs are synchronous to clk. No internal synchronizers, no FSM inside this block.

Optional Feature:
- Macro ROUTER_REG_BUSY_CNT_EN.
- Defined:
  - Adds output busy_cnt[CNT_W-1:0].
  - Increments by 1 on every rising edge where the registered busy is 1 and resetn=0.
  - Saturates at all-ones with no wrap.
  - Cleared to 0 by resetn.
  - busy behaviour is unchanged.
- Undefined:
  - Port busy_cnt and its counter logic do not exist.
  - busy behaviour is identical to the defined case.

Test Plan:
- resetn=1 for 2 cycles with detect_add=1 -> busy=0 throughout. Deassert resetn -> busy=1 one edge later.
- detect_add=1 only -> busy=1 after 1 edge. Then ld_state=1 only -> busy=1. Then all inputs 0 -> busy=0 after 1 edge.
- laf_state=1, full_state=1, pkt_valid=1 -> busy=1. Drop pkt_valid -> busy=0 next edge. Drop full_state -> busy=1 next edge.
- empty_state=1, write_enb_reg=1 -> busy=1. Clear write_enb_reg -> busy=0. Then rst_int_reg=1 alone -> busy=1.
- Latency check: change an input at negedge. busy must not change before the following posedge, and must reflect it at that posedge.
- With ROUTER_REG_BUSY_CNT_EN and CNT_W=2:
  - Hold detect_add=1 for 6 cycles -> busy_cnt saturates at 3.
  - Assert resetn -> busy_cnt=0 and busy=0 next edge.
